// File: rtl/universal_counter_md.sv
// Multi-digit cascaded up/down counter with hex or BCD digits, parallel load,
// terminal-count detect, registered wrap pulse and optional saturation.
module universal_counter_md #(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  mode,
  input  logic                  incr,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] step_val;
  logic [W-1:0] max_val;
  logic         tc_c;
  logic         en;
  logic [4:0]   dig;

  // Returns {carry/borrow, next digit}. Decimal rules also absorb illegal A..F digits.
  function automatic logic [4:0] step_digit(input logic [3:0] d, input logic hex, input logic up);
    logic [4:0] r;
    if (up) begin
      if (hex ? (d == 4'hF) : (d >= 4'd9)) r = {1'b1, 4'h0};
      else                                 r = {1'b0, d + 4'd1};
    end else begin
      if (d == 4'h0)                       r = {1'b1, hex ? 4'hF : 4'h9};
      else if (!hex && (d > 4'd9))         r = {1'b0, 4'h9};
      else                                 r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    step_val = count_q;
    max_val  = '0;
    en       = 1'b1;
    dig      = '0;
    // Ripple the carry/borrow chain through all digits within one cycle.
    for (int i = 0; i < DIGITS; i++) begin
      max_val[4*i +: 4] = mode ? 4'hF : 4'h9;
      dig = step_digit(count_q[4*i +: 4], mode, incr);
      if (en) begin
        step_val[4*i +: 4] = dig[3:0];
        en                 = dig[4];
      end
    end
    tc_c = incr ? (count_q == max_val) : (count_q == '0);
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (!pause) begin
      if (!(tc_c && SATURATE)) begin
        count_d = step_val;
        ovf_d   = tc_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign tc    = tc_c;

endmodule

// File: tb/tb_universal_counter_md.sv
// Directed bench for universal_counter_md: a wrapping 2-digit instance and a
// saturating 3-digit instance, expected values queued at drive time and popped after the edge.
module tb_universal_counter_md;

  logic        clk = 1'b0;
  logic        rst_n, clear, load, mode, incr, pause;
  logic [7:0]  lv_a;
  logic [11:0] lv_b;
  logic [7:0]  count_a;
  logic [11:0] count_b;
  logic        tc_a, tc_b, ovf_a, ovf_b;

  int checks = 0;
  int errs   = 0;

  typedef struct {
    string       tag;
    bit          which;
    logic [11:0] cnt;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  universal_counter_md #(.DIGITS(2), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(lv_a),
    .mode(mode), .incr(incr), .pause(pause), .count(count_a), .tc(tc_a), .ovf(ovf_a));

  universal_counter_md #(.DIGITS(3), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(lv_b),
    .mode(mode), .incr(incr), .pause(pause), .count(count_b), .tc(tc_b), .ovf(ovf_b));

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic c, input logic l, input logic [11:0] lv,
                       input logic m, input logic inc, input logic p);
    rst_n = r; clear = c; load = l; lv_a = lv[7:0]; lv_b = lv;
    mode = m; incr = inc; pause = p;
  endtask

  // Queue the expectation, clock once, then pop and compare away from the edge.
  task automatic cyc(input string tag, input bit which, input logic [11:0] ec, input logic eo);
    exp_t e;
    logic [11:0] oc;
    logic        oo;
    e.tag = tag; e.which = which; e.cnt = ec; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    oc = e.which ? count_b : {4'h0, count_a};
    oo = e.which ? ovf_b : ovf_a;
    checks++;
    assert (oc === e.cnt) else begin
      errs++;
      $error("FAIL %s count: observed=%h expected=%h", e.tag, oc, e.cnt);
    end
    checks++;
    assert (oo === e.ovf) else begin
      errs++;
      $error("FAIL %s ovf: observed=%b expected=%b", e.tag, oo, e.ovf);
    end
  endtask

  task automatic chk_tc(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s tc: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic r_inc;
    r_inc = 1'($urandom);
    // Reset with random data inputs, clear and load asserted
    drive(1'b0, 1'b1, 1'b1, 12'($urandom), 1'($urandom), r_inc, 1'($urandom));
    cyc("rst_a", 1'b0, 12'h000, 1'b0);
    chk_tc("rst_a", tc_a, ~r_inc);
    checks++;
    assert (count_b === 12'h000 && ovf_b === 1'b0) else begin
      errs++;
      $error("FAIL rst_b: observed=%h/%b expected=000/0", count_b, ovf_b);
    end

    // Decimal up
    drive(1'b1, 1'b0, 1'b1, 12'h098, 1'b0, 1'b1, 1'b0); cyc("ld98", 0, 12'h098, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0); cyc("dec_up99", 0, 12'h099, 1'b0);
    chk_tc("dec_max", tc_a, 1'b1);
    cyc("dec_wrap", 0, 12'h000, 1'b1);
    chk_tc("dec_after_wrap", tc_a, 1'b0);
    cyc("dec_01", 0, 12'h001, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h009, 1'b0, 1'b1, 1'b0); cyc("ld09", 0, 12'h009, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0); cyc("dec_ripple", 0, 12'h010, 1'b0);

    // Decimal down
    drive(1'b1, 1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0); cyc("ld10", 0, 12'h010, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0); cyc("dec_dn09", 0, 12'h009, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0); cyc("ld00", 0, 12'h000, 1'b0);
    chk_tc("dec_min", tc_a, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0); cyc("dec_dnwrap", 0, 12'h099, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 12'h00C, 1'b0, 1'b0, 1'b0); cyc("ld0C", 0, 12'h00C, 1'b0);
    chk_tc("dec_illegal", tc_a, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0); cyc("dec_illegal_dn", 0, 12'h009, 1'b0);

    // Hexadecimal
    drive(1'b1, 1'b0, 1'b1, 12'h0FF, 1'b1, 1'b1, 1'b0); cyc("ldFF", 0, 12'h0FF, 1'b0);
    chk_tc("hex_max", tc_a, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0); cyc("hex_upwrap", 0, 12'h000, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0); cyc("hex_dnwrap", 0, 12'h0FF, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 12'h03F, 1'b1, 1'b1, 1'b0); cyc("ld3F", 0, 12'h03F, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0); cyc("hex_ripple", 0, 12'h040, 1'b0);

    // Pause after a wrap, then priority cases
    drive(1'b1, 1'b0, 1'b1, 12'h0FF, 1'b1, 1'b1, 1'b0); cyc("ldFF2", 0, 12'h0FF, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0); cyc("wrap2", 0, 12'h000, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc("pause", 0, 12'h000, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'h055, 1'b1, 1'b1, 1'b0); cyc("clr_beats_ld", 0, 12'h000, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h0A7, 1'b0, 1'b1, 1'b1); cyc("ld_beats_pause", 0, 12'h0A7, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h0FF, 1'b1, 1'b1, 1'b0); cyc("ldFF3", 0, 12'h0FF, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0); cyc("clr_midwrap", 0, 12'h000, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h0FF, 1'b1, 1'b1, 1'b0); cyc("ldFF4", 0, 12'h0FF, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0); cyc("rst_midwrap", 0, 12'h000, 1'b0);

    // Saturating 3-digit decimal instance
    drive(1'b1, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0); cyc("ld999", 1, 12'h999, 1'b0);
    chk_tc("sat_max", tc_b, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    cyc("sat_hold_up", 1, 12'h999, 1'b0);
    cyc("sat_hold_up2", 1, 12'h999, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0); cyc("sat_resume", 1, 12'h998, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0); cyc("ld000", 1, 12'h000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0); cyc("sat_hold_dn", 1, 12'h000, 1'b0);
    chk_tc("sat_min", tc_b, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0); cyc("sat_resume_up", 1, 12'h001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
